// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the PC register.
package ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  // Fetch FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DROP = 2'd3;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction-fetch stage: one imem req/ack transaction per fetch, result held in
// the instruction register with a valid/ready handoff to decode.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               fetch_en,
  input  logic               flush,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [31:0]        ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               pc_write,
  output logic [31:0]        npc_seq,
  output logic               misalign
);

  state_t state;

  assign npc_seq = ir_pc + 32'd4;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      ir        <= '0;
      ir_pc     <= RESET_PC;
      ir_valid  <= 1'b0;
      pc_write  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      // NOTE: pc_write defaults low every cycle so it can only ever be a single-cycle pulse.
      pc_write <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_en) begin
            if (pc_aligned(pc)) begin
              imem_addr <= pc;
              imem_req  <= 1'b1;
              state     <= REQ;
            end else begin
              misalign <= 1'b1;
            end
          end
        end

        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              ir       <= imem_rdata;
              ir_pc    <= imem_addr;
              ir_valid <= 1'b1;
              pc_write <= 1'b1;
              state    <= HOLD;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end

        // Request must stay up until memory answers; the data is thrown away.
        DROP: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end

        HOLD: begin
          if (flush) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
            if (fetch_en) begin
              if (pc_aligned(pc)) begin
                imem_addr <= pc;
                imem_req  <= 1'b1;
                state     <= REQ;
              end else begin
                misalign <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the multicycle datapath, sitting directly downstream of the PC register. It takes the current PC, runs a request/acknowledge transaction with instruction memory, and latches the returned word into an instruction register with a valid/ready handoff to decode. On every completed fetch it drives a one-cycle `pc_write` strobe and the sequential next PC, `npc_seq`, back to the PC register.

## Interface
- `RESET_PC`, default 32'h0000_3000: reset value for `imem_addr`/`ir_pc`; must equal the PC register's reset value.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assertion, active-low (0 = reset).
- `pc`  in  32  current PC from the PC register.
- `fetch_en`  in  1  controller request to fetch the instruction at `pc`.
- `flush`  in  1  discard any in-flight fetch and the IR contents (branch/jump taken).
- `imem_req`  out  1  memory request, registered.
- `imem_addr`  out  32  fetch address, registered, stable while `imem_req`=1.
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  instruction register.
- `ir_pc`  out  32  address `ir` was fetched from.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  decode accepts `ir` this cycle.
- `pc_write`  out  1  one-cycle strobe: PC register loads `npc_seq`.
- `npc_seq`  out  32  `ir_pc` + 4, combinational, modulo 2^32.
- `misalign`  out  1  sticky error: fetch attempted with `pc[1:0]` != 0.

## Operation
- FSM states: IDLE, REQ, HOLD, DROP.
- IDLE: if `fetch_en` and `pc[1:0]`==0, latch `imem_addr`<=`pc`, set `imem_req`, go to REQ. If `fetch_en` and misaligned, set `misalign`, no request, stay IDLE.
- REQ: hold `imem_req`/`imem_addr`.
  - `imem_ack` without `flush`: `ir`<=`imem_rdata`, `ir_pc`<=`imem_addr`, `ir_valid`<=1, `pc_write`<=1, `imem_req`<=0; go to HOLD.
  - `imem_ack` with `flush`: discard data, no `pc_write`, `imem_req`<=0; go to IDLE.
  - `flush` without `imem_ack`: go to DROP.
- DROP: `imem_req` stays high until `imem_ack`. On `imem_ack`, discard data, drop `imem_req`, go to IDLE. Further `flush` is ignored.
- HOLD: `ir_valid`=1.
  - `flush`: clear `ir_valid`, go to IDLE. `flush` has priority over `ir_ready`.
  - `ir_ready`: clear `ir_valid`. If `fetch_en` in the same cycle and `pc` is aligned, issue the next request directly (go to REQ). Otherwise go to IDLE.
  - Neither: hold `ir`/`ir_pc` unchanged.
- `pc_write` is high for exactly one cycle per captured instruction and is never asserted in any other case.
- Request rule: once `imem_req` rises it never falls before `imem_ack`. `imem_addr` never changes while `imem_req`=1.
- `misalign` is cleared only by reset.

## Timing
- Reset values: state IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `ir`=0, `ir_pc`=`RESET_PC`, `ir_valid`=0, `pc_write`=0, `misalign`=0, so `npc_seq`=`RESET_PC`+4.
- Reset asserted mid-transaction: all state returns to reset values immediately. Memory must tolerate a request being abandoned.
- Fetch latency:
  - `fetch_en` high in IDLE at cycle 0 → `imem_req` high in cycle 1.
  - `imem_ack` in cycle k → `ir_valid` and `pc_write` high in cycle k+1.
  - Zero-wait memory (`imem_ack` in cycle 1) → instruction available in cycle 2.
- `npc_seq` is valid in the same cycle as `pc_write`, so the PC register updates at the end of cycle k+1.
- Back-to-back issue: `ir_ready` and `fetch_en` in cycle n → `imem_req` high in cycle n+1. With zero-wait memory, throughput is one instruction per 2 cycles.
- `ir_pc` = 32'hFFFF_FFFC gives `npc_seq` = 0 (wrap).

## Structure
- Shared package `ifetch_pkg`:
  - state enum (IDLE, REQ, HOLD, DROP);
  - constant `PC_RESET` = 32'h0000_3000, also used by the PC register;
  - `INSTR_W` = 32.
- Single module, no sub-modules. The `npc_seq` adder is inline.

## Test plan
- Reset then single fetch: pulse `rst`=0, release; `pc`=0x3000, `fetch_en` at cycle 0, `imem_ack` in cycle 3 with rdata 0x2008_0005 → `ir`=0x2008_0005, `ir_pc`=0x3000, `ir_valid`=1, one-cycle `pc_write`, `npc_seq`=0x3004 in cycle 4.
- Backpressure: hold `ir_ready`=0 for 5 cycles → `ir`/`ir_valid` stable, no extra `pc_write`. Then `ir_ready`+`fetch_en` with `pc`=0x3004 → `imem_req` next cycle, `imem_addr`=0x3004.
- Flush in REQ: `flush` 1 cycle before `imem_ack` → `imem_req` held until ack, no `ir_valid`, no `pc_write`, state back to IDLE. Repeat with `flush` coincident with `imem_ack`: same outcome.
- Flush vs ready in HOLD: `flush`=1 and `ir_ready`=1 together → `ir_valid`=0, no new request even with `fetch_en`=1.
- Misaligned PC: `pc`=0x3002, `fetch_en`=1 → `misalign`=1 sticky, `imem_req` stays 0. `rst` clears `misalign`.
- Wrap and async reset: `pc`=0xFFFF_FFFC fetch → `npc_seq`=0. Assert `rst` while `imem_req`=1 → `imem_req`=0 and `imem_addr`=0x3000 with no clock edge.
